// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StIssue,
        StDrain,
        StDone
    } seq_state_e;

    // OPMODE field positions (X mux, Z mux, pre-adder, carry, pre-sub, post-sub)
    localparam int unsigned OpmXLsb    = 0;
    localparam int unsigned OpmZLsb    = 2;
    localparam int unsigned OpmPreAdd  = 4;
    localparam int unsigned OpmCarryIn = 5;
    localparam int unsigned OpmPreSub  = 6;
    localparam int unsigned OpmPostSub = 7;

    localparam logic [1:0] OpmXM    = 2'b01;
    localparam logic [1:0] OpmZZero = 2'b00;
    localparam logic [1:0] OpmZP    = 2'b10;

    function automatic logic [7:0] make_opmode(input logic [1:0] x, input logic [1:0] z);
        logic [7:0] opm;
        opm = '0;
        opm[OpmXLsb +: 2] = x;
        opm[OpmZLsb +: 2] = z;
        return opm;
    endfunction

    localparam logic [7:0] OpmFirst = make_opmode(OpmXM, OpmZZero);
    localparam logic [7:0] OpmAcc   = make_opmode(OpmXM, OpmZP);

endpackage

// File: rtl/opm_align_sr.sv
// CE-gated shift register that delays the "first term" flag so OPMODE lines up
// with the product it governs inside the slice pipeline.
module opm_align_sr #(
    parameter int unsigned Depth = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ce,
    input  logic first_in,
    output logic first_out
);

    logic [Depth-1:0] sr_q;
    logic [Depth-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = first_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (ce) begin
            sr_q <= sr_d;
        end
    end

    assign first_out = sr_q[Depth-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice through N-term multiply-accumulate jobs and
// captures the final accumulator behind a valid/ready result port.
module dsp48a1_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int unsigned A_W      = 18,
    parameter int unsigned B_W      = 18,
    parameter int unsigned P_W      = 48,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned OPM_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [A_W-1:0]   op_a,
    input  logic [B_W-1:0]   op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [P_W-1:0]   res_data,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic             dsp_ce,
    output logic             dsp_rst,
    output logic [7:0]       dsp_opmode,
    input  logic [P_W-1:0]   dsp_p
);

    localparam int unsigned DrainW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(PIPE_LAT - 1);

    seq_state_e        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt_q;
    logic [DrainW-1:0] drain_cnt_q;
    logic              abort_flush_q;
    logic [P_W-1:0]    res_data_q;

    logic accept;
    logic last_term;
    logic first_accept;
    logic first_dly;

    assign accept       = op_valid && (state_q == StIssue);
    assign last_term    = (issue_cnt_q == len_q - LEN_W'(1));
    assign first_accept = accept && (issue_cnt_q == '0);

    // Slice is frozen whenever the operand stream stalls; drain runs PIPE_LAT-1 edges.
    assign dsp_ce  = accept || ((state_q == StDrain) && (drain_cnt_q != DrainLast));
    assign dsp_rst = (state_q == StFlush);
    assign dsp_a   = op_a;
    assign dsp_b   = op_b;

    assign cmd_ready = (state_q == StIdle);
    assign op_ready  = (state_q == StIssue);
    assign res_valid = (state_q == StDone);
    assign res_data  = res_data_q;

    opm_align_sr #(
        .Depth (OPM_LAT)
    ) u_opm_align_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort),
        .ce        (dsp_ce),
        .first_in  (first_accept),
        .first_out (first_dly)
    );

    assign dsp_opmode = first_dly ? OpmFirst : OpmAcc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            len_q         <= '0;
            issue_cnt_q   <= '0;
            drain_cnt_q   <= '0;
            abort_flush_q <= 1'b0;
            res_data_q    <= '0;
        end else if (abort) begin
            state_q       <= StFlush;
            abort_flush_q <= 1'b1;
            issue_cnt_q   <= '0;
            drain_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        len_q       <= cmd_len;
                        issue_cnt_q <= '0;
                        drain_cnt_q <= '0;
                        if (cmd_len == '0) begin
                            res_data_q <= '0;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    abort_flush_q <= 1'b0;
                    state_q       <= abort_flush_q ? StIdle : StIssue;
                end
                StIssue: begin
                    if (op_valid) begin
                        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
                        if (last_term) begin
                            drain_cnt_q <= '0;
                            state_q     <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainLast) begin
                        res_data_q <= dsp_p;
                        state_q    <= StDone;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DrainW'(1);
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
